// File: rtl/score_update_arbiter.sv
// Round-robin arbiter that funnels scoring events into one saturating score accumulator.
// Optional combo multiplier is enabled by defining SCORE_COMBO_EN.
module score_update_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          PTS_W        = 8,
  parameter int          SCORE_W      = 32,
  parameter int unsigned SCORE_MAX    = 99999999,
  parameter int unsigned COMBO_WINDOW = 50000000,
  parameter int unsigned COMBO_MAX    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             game_state,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PTS_W-1:0] pts,
  output logic [N_REQ-1:0]       grant,
  output logic [SCORE_W-1:0]     score_count,
  output logic [2:0]             combo_level
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [SCORE_W:0] SCORE_CEIL = (SCORE_W+1)'(SCORE_MAX);

  typedef enum logic [1:0] {
    MODE_START,
    MODE_RUN,
    MODE_HOLD
  } mode_t;

  logic [3:0]             game_state_q;
  logic [N_REQ-1:0]       req_q;
  logic [N_REQ*PTS_W-1:0] pts_q;
  logic [PTR_W-1:0]       ptr;
  mode_t                  mode;

  logic [N_REQ-1:0]   eligible;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic [N_REQ-1:0]   win_onehot;
  logic [PTS_W-1:0]   win_pts;
  logic [2:0]         mult;
  logic [PTS_W+2:0]   add_val;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_score;

  // Anything that is not a clean one-hot IN_GAME or START_SCREEN freezes the block.
  always_comb begin
    mode = MODE_HOLD;
    case (game_state_q)
      4'b0001: mode = MODE_START;
      4'b0010: mode = MODE_RUN;
      default: mode = MODE_HOLD;
    endcase
  end

  // Masking by the current grant keeps a still-registered request from winning twice.
  always_comb begin
    eligible = req_q & ~grant;
    found    = 1'b0;
    winner   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && eligible[(int'(ptr) + i) % N_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(ptr) + i) % N_REQ);
      end
    end
    next_ptr   = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    win_onehot = found ? (N_REQ'(1) << winner) : '0;
    win_pts    = pts_q[int'(winner)*PTS_W +: PTS_W];
    add_val    = {3'b000, win_pts} * {{PTS_W{1'b0}}, mult};
    sum        = {1'b0, score_count} + {{(SCORE_W-PTS_W-2){1'b0}}, add_val};
    new_score  = (sum > SCORE_CEIL) ? SCORE_CEIL[SCORE_W-1:0] : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_state_q <= '0;
      req_q        <= '0;
      pts_q        <= '0;
      ptr          <= '0;
      grant        <= '0;
      score_count  <= '0;
    end else begin
      game_state_q <= game_state;
      req_q        <= req;
      pts_q        <= pts;
      case (mode)
        MODE_START: begin
          grant       <= '0;
          ptr         <= '0;
          score_count <= '0;
        end
        MODE_RUN: begin
          grant <= win_onehot;
          if (found) begin
            ptr         <= next_ptr;
            score_count <= new_score;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

`ifdef SCORE_COMBO_EN
  localparam int TMR_W = $clog2(COMBO_WINDOW + 1);
  localparam logic [TMR_W-1:0] WIN_LIMIT = TMR_W'(COMBO_WINDOW);
  localparam logic [2:0]       LVL_MAX   = 3'(COMBO_MAX);

  logic [TMR_W-1:0] combo_timer;
  logic [2:0]       combo_q;

  // The add above uses combo_q as it stands; the bump lands on the same edge as the add.
  always_ff @(posedge clk) begin
    if (rst) begin
      combo_timer <= '0;
      combo_q     <= 3'd1;
    end else begin
      case (mode)
        MODE_START: begin
          combo_timer <= '0;
          combo_q     <= 3'd1;
        end
        MODE_RUN: begin
          if (found) begin
            combo_timer <= '0;
            if (combo_timer < WIN_LIMIT)
              combo_q <= (combo_q >= LVL_MAX) ? LVL_MAX : combo_q + 3'd1;
          end else if (combo_timer < WIN_LIMIT) begin
            combo_timer <= combo_timer + 1'b1;
            if (combo_timer + 1'b1 == WIN_LIMIT)
              combo_q <= 3'd1;
          end
        end
        default: begin
          combo_timer <= combo_timer;
          combo_q     <= combo_q;
        end
      endcase
    end
  end

  assign mult        = combo_q;
  assign combo_level = combo_q;
`else
  assign mult        = 3'd1;
  assign combo_level = 3'd1;
`endif

endmodule
